// File: rtl/athena_trackball.sv
// rtl/athena_trackball.sv - d-pad to trackball emulation with per-axis ramp/hold acceleration
// Optional acceleration: define ATHENA_TRACKBALL_ACCEL_EN; otherwise a pressed key jumps straight to MAX_STEP.
module athena_trackball #(
  parameter int          SAMPLE_PERIOD = 1160000,
  parameter logic [7:0]  MIN_STEP      = 8'd16,
  parameter logic [7:0]  ACCEL_STEP    = 8'd8,
  parameter logic [7:0]  MAX_STEP      = 8'd64
) (
  input  logic       clk_74a,
  input  logic       reset,
  input  logic       dpad_up,
  input  logic       dpad_down,
  input  logic       dpad_left,
  input  logic       dpad_right,
  input  logic       pause,
  output logic [7:0] trackball_x,
  output logic [7:0] trackball_y,
  output logic       tick
);

  localparam int             CW   = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0]  LAST = CW'(SAMPLE_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

  typedef struct packed {
    state_t     state;
    logic [7:0] mag;
    logic       neg;
  } axis_t;

  logic [CW-1:0] cnt;
  logic          up_q, down_q, left_q, right_q;
  axis_t         x_ax, y_ax;

  // p/n are the positive- and negative-direction keys of one axis
  function automatic axis_t step(input axis_t cur, input logic p, input logic n);
    axis_t      nx;
    logic [8:0] sum;
    nx  = cur;
    sum = {1'b0, cur.mag} + {1'b0, ACCEL_STEP};
    if (p == n) begin
      nx = '{IDLE, 8'd0, 1'b0};
    end else if (cur.state == IDLE || cur.neg != n) begin
`ifdef ATHENA_TRACKBALL_ACCEL_EN
      nx = '{RAMP, MIN_STEP, n};
`else
      nx = '{HOLD, MAX_STEP, n};
`endif
    end else if (cur.state == RAMP) begin
      if (sum >= {1'b0, MAX_STEP}) nx = '{HOLD, MAX_STEP, n};
      else                         nx = '{RAMP, sum[7:0], n};
    end else begin
      nx = '{HOLD, MAX_STEP, n};
    end
    return nx;
  endfunction

  function automatic logic [7:0] value(input axis_t a);
    return a.neg ? (~a.mag + 8'd1) : a.mag;
  endfunction

  assign tick = (cnt == LAST) && !pause && !reset;

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      cnt         <= '0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      x_ax        <= '{IDLE, 8'd0, 1'b0};
      y_ax        <= '{IDLE, 8'd0, 1'b0};
      trackball_x <= 8'h00;
      trackball_y <= 8'h00;
    end else begin
      up_q    <= dpad_up;
      down_q  <= dpad_down;
      left_q  <= dpad_left;
      right_q <= dpad_right;
      if (pause) begin
        // counter holds so the window resumes where it stopped
        x_ax        <= '{IDLE, 8'd0, 1'b0};
        y_ax        <= '{IDLE, 8'd0, 1'b0};
        trackball_x <= 8'h00;
        trackball_y <= 8'h00;
      end else if (cnt == LAST) begin
        cnt         <= '0;
        x_ax        <= step(x_ax, right_q, left_q);
        y_ax        <= step(y_ax, down_q, up_q);
        trackball_x <= value(step(x_ax, right_q, left_q));
        trackball_y <= value(step(y_ax, down_q, up_q));
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/athena_trackball.md
ATHENA_TRACKBALL -- requirements
Module: athena_trackball

Interface
REQ-001 The module SHALL have parameter SAMPLE_PERIOD, default 1160000, meaning clocks per sample tick (minimum 2).
REQ-002 The module SHALL have parameter MIN_STEP, default 8'd16, meaning the first-tick displacement magnitude.
REQ-003 The module SHALL have parameter ACCEL_STEP, default 8'd8, meaning the magnitude increment per held tick.
REQ-004 The module SHALL have parameter MAX_STEP, default 8'd64, meaning the magnitude ceiling (at most 127, at least MIN_STEP).
REQ-005 The module SHALL have port clk_74a, input, 1 bit: the single clock.
REQ-006 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have ports dpad_up, dpad_down, dpad_left, dpad_right, each input, 1 bit, active-high, from player-1 keys.
REQ-008 The module SHALL have port pause, input, 1 bit: high while the core is paused or the menu is open.
REQ-009 The module SHALL have port trackball_x, output, 8 bits: signed two's-complement X displacement for the current tick window.
REQ-010 The module SHALL have port trackball_y, output, 8 bits: signed two's-complement Y displacement for the current tick window.
REQ-011 The module SHALL have port tick, output, 1 bit: a one-clock pulse when trackball_x and trackball_y update.

Function
REQ-012 Tick counter: counts 0..SAMPLE_PERIOD-1 and wraps to 0; tick SHALL be high for exactly the clock in which the counter equals SAMPLE_PERIOD-1.
REQ-013 Direction inputs SHALL be registered once; all decisions use the registered values sampled on the tick clock.
REQ-014 Each axis SHALL run an independent FSM with states IDLE, RAMP and HOLD, evaluated only on tick clocks.
REQ-015 Axis direction: X positive = right, negative = left; Y positive = down, negative = up.
REQ-016 Axis with neither key pressed, or with both opposing keys pressed, SHALL go to IDLE, magnitude 0, output 8'h00.
REQ-017 IDLE with one key pressed SHALL go to RAMP with magnitude = MIN_STEP.
REQ-018 RAMP with the same key still pressed SHALL add ACCEL_STEP to the magnitude, saturating at MAX_STEP, and SHALL go to HOLD when MAX_STEP is reached.
REQ-019 HOLD with the same key still pressed SHALL keep magnitude MAX_STEP.
REQ-020 Direction reversal (the opposite single key pressed) in RAMP or HOLD SHALL restart RAMP with magnitude MIN_STEP in the new direction, with no zero tick in between.
REQ-021 The magnitude sum SHALL use a 9-bit intermediate so that saturation never wraps.
REQ-022 Output update: on the tick clock, trackball_x/y SHALL take +magnitude or -magnitude (two's complement) of the new state, and SHALL hold that value until the next tick.
REQ-023 Latency: a key change SHALL appear on the output at the first tick at least 2 clocks after the change (1 input-register stage).
REQ-024 Pause high SHALL freeze the counter, suppress tick, force both FSMs to IDLE and force both outputs to 8'h00 on the next clock.
REQ-025 When pause falls, counting SHALL resume from the frozen value.

Reset
REQ-026 Reset high SHALL set, on the next clk_74a edge: counter 0, both FSMs IDLE, magnitudes 0, trackball_x = trackball_y = 8'h00, tick = 0, input registers 0.
REQ-027 Reset SHALL take priority over pause and over tick, including when reset is asserted mid-window or in the same clock as tick.

Configuration
REQ-028 Macro ATHENA_TRACKBALL_ACCEL_EN defined: the RAMP/HOLD acceleration of REQ-017..REQ-021 SHALL apply.
REQ-029 Macro ATHENA_TRACKBALL_ACCEL_EN undefined: any single pressed key SHALL go directly to HOLD with magnitude MAX_STEP, RAMP SHALL be unreachable, ACCEL_STEP SHALL be ignored, and all other behaviour SHALL be unchanged.

Verification (bench SAMPLE_PERIOD=16, defaults otherwise, ACCEL_EN defined unless stated)
REQ-030 Scenario: release reset with no keys for 64 clocks -> tick pulses at clocks 15, 31, 47, 63 after release; both outputs stay 8'h00.
REQ-031 Scenario: hold dpad_right -> trackball_x at successive ticks = 8'h10, 8'h18, 8'h20, ... 8'h40, then stays 8'h40 (HOLD); trackball_y stays 8'h00.
REQ-032 Scenario: hold dpad_up to HOLD, then switch to dpad_down -> trackball_y goes from 8'hC0 directly to 8'h10 at the next tick.
REQ-033 Scenario: press dpad_left and dpad_right together -> trackball_x = 8'h00 at the next tick and the X FSM is in IDLE.
REQ-034 Scenario: assert pause for 40 clocks mid-ramp -> no tick, outputs 8'h00; after pause falls, the first tick occurs at the remaining count and the ramp restarts at 8'h10.
REQ-035 Scenario: ACCEL_EN undefined, hold dpad_left -> trackball_x = 8'hC0 from the first tick onward.
